mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-port 256x16 synchronous program/data memory between two requesters.
  - Port 0: processor ADDR/DOUT/W path.
  - Port 1: external loader/debug master.
- Round-robin arbitration with a bounded burst lock, and a registered grant per port.
- Read data is returned one cycle after an accepted read, matching the memory's registered-address latency.
- Sits between the processor top level and the memory instance, replacing the processor's direct connection.

Parameters:
AW, 8, address width
DW, 16, data width
MAX_BURST, 4, maximum accepted accesses per grant while the other port is requesting (>=1)

Ports:
clk_50MHz  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
req0  input  1  port 0 access request (processor)
we0  input  1  port 0 write enable (1 = write, 0 = read)
addr0  input  AW  port 0 address
wdata0  input  DW  port 0 write data
gnt0  output  1  port 0 owns memory this cycle (registered)
rvalid0  output  1  rdata valid for port 0 read accepted last cycle
req1, we1, addr1, wdata1, gnt1, rvalid1  same as port 0, for port 1
rdata  output  DW  mem_q passed through, shared by both ports
mem_addr  output  AW  memory address
mem_data  output  DW  memory write data
mem_wren  output  1  memory write enable
mem_q  input  DW  memory read data (valid one cycle after address)
owner  output  2  debug: 00 idle, 01 port0, 10 port1

Behaviour:
- FSM states: IDLE, OWN0, OWN1. gnt0 = (state==OWN0) and gnt1 = (state==OWN1), both decoded from registered state.
- Accept rule: an access on port k is accepted in a cycle where gnt_k & req_k.
  - Accepted: mem_addr=addr_k, mem_data=wdata_k, mem_wren=we_k.
  - Not accepted: mem_wren=0, mem_addr=0, mem_data=0.
- A requester holds req/addr/we/wdata until it sees gnt; each cycle with gnt & req is one access. Back-to-back accesses are allowed.
- rvalid_k registered: set the cycle after an accepted read (we_k=0); cleared otherwise. Writes never raise rvalid.
- last register (1 bit): the port granted most recently. Reset value 1, so port 0 wins the first tie.
- burst counter (width clog2(MAX_BURST+1)):
  - Cleared on every state change.
  - Increments per accepted access.
  - Saturates at MAX_BURST.
- Transitions, evaluated on current-cycle inputs:
  - IDLE:
    - Only req0 high -> OWN0.
    - Only req1 high -> OWN1.
    - Both high -> the port != last.
    - Neither high -> stay IDLE.
    - Grant appears one cycle after req, so first-access latency from IDLE is 1 cycle.
  - OWNk, req_k low:
    - Other port requesting -> OWN(other).
    - Otherwise -> IDLE.
  - OWNk, req_k high, other requesting, and this cycle's acceptance brings count to MAX_BURST -> OWN(other), with no bubble.
  - OWNk, req_k high, other port not requesting -> stay OWNk. No burst limit applies.
  - On entering OWNk, last <= k.
- Handover: the releasing port's gnt drops and the other's rises on the same edge. No overlap is ever permitted: gnt0 & gnt1 == 0 in every cycle.
- An in-flight read completes across a handover. rvalid is tied to the port that issued the read, not the current owner.
- Reset (async, any time): state=IDLE, gnt0=gnt1=0, rvalid0=rvalid1=0, count=0, last=1. mem_wren=0 immediately. A pending read return is discarded.
- rdata is combinational mem_q with no register. Consumers sample it only when rvalid_k is high.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encoding constants (IDLE=2'b00, OWN0=2'b01, OWN1=2'b10), reused for the owner output;
  - port index constants.
- One natural sub-module: rr_pick. This is the combinational two-way round-robin selector with inputs req0, req1, last and outputs a valid flag plus the chosen port. The FSM instantiates it for the IDLE decision and for the handover decision.
- The burst counter and the memory mux stay inline.

Test Plan:
- Reset behaviour: assert reset with req0=1 mid-burst -> gnt0, rvalid0 and mem_wren drop the same cycle. After release, first grant goes to port 0.
- Single-port read: req0=1, we0=0, addr0=8'h10, mem holds 16'hABCD -> gnt0 high next cycle, mem_addr=8'h10, rvalid0 high the cycle after, rdata=16'hABCD.
- Write then readback on port 1: write 16'h1234 to 8'h20, then read 8'h20 -> mem_wren pulses exactly one cycle, and the read returns 16'h1234 with rvalid1.
- Contention: both req held continuously, MAX_BURST=4 -> grant pattern of 4 accepted cycles port0, then 4 port1, alternating, no idle cycle between. Check gnt0 & gnt1 is never 1.
- Uncontested burst: req1 held 10 cycles with req0=0 -> gnt1 for all 10 accesses. req0 rising mid-burst takes ownership after at most 4 further port 1 accesses.
- Handover with in-flight read: port 0 reads 8'h05 on the last burst cycle while req1 is pending -> rvalid0 asserts in the first OWN1 cycle, and rvalid1 does not.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the two-port memory arbiter.
// State values double as the debug owner code.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_e;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Two-way round-robin selector.
// On a tie the port that was not granted last wins.
module rr_pick
    import mem_arb_pkg::*;
(
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_i,
    output logic valid_o,
    output logic pick_o
);

    always_comb begin
        valid_o = req0_i | req1_i;
        pick_o  = PORT0;
        if (req0_i && req1_i) begin
            pick_o = ~last_i;
        end else if (req1_i) begin
            pick_o = PORT1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous 256x16 memory
// between the processor (port 0) and a loader/debug master (port 1).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW        = 8,
    parameter int DW        = 16,
    parameter int MAX_BURST = 4
) (
    input  logic          clk_50MHz,
    input  logic          reset,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          rvalid0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data,
    output logic          mem_wren,
    input  logic [DW-1:0] mem_q,
    output logic [1:0]    owner
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] MAXB = CW'(MAX_BURST);

    state_e        state_q, state_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rvalid0_q, rvalid1_q;
    logic          acc0, acc1;
    logic          pick_valid, pick_port;
    logic          burst_end;

    assign gnt0    = (state_q == OWN0);
    assign gnt1    = (state_q == OWN1);
    assign owner   = state_q;
    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata   = mem_q;

    assign acc0 = gnt0 & req0;
    assign acc1 = gnt1 & req1;

    // Current owner's request is masked so the same picker
    // serves both the idle choice and the handover target.
    rr_pick u_pick (
        .req0_i  (req0 & (state_q != OWN0)),
        .req1_i  (req1 & (state_q != OWN1)),
        .last_i  (last_q),
        .valid_o (pick_valid),
        .pick_o  (pick_port)
    );

    assign burst_end = (cnt_q >= MAXB - 1'b1);

    always_comb begin
        mem_addr = '0;
        mem_data = '0;
        mem_wren = 1'b0;
        unique case (1'b1)
            acc0: begin
                mem_addr = addr0;
                mem_data = wdata0;
                mem_wren = we0;
            end
            acc1: begin
                mem_addr = addr1;
                mem_data = wdata1;
                mem_wren = we1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = pick_port ? OWN1 : OWN0;
                end
            end
            OWN0: begin
                if (!req0 || (pick_valid && burst_end)) begin
                    state_d = pick_valid ? OWN1 : IDLE;
                end
            end
            OWN1: begin
                if (!req1 || (pick_valid && burst_end)) begin
                    state_d = pick_valid ? OWN0 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) begin
            cnt_d = '0;
            if (state_d == OWN0) begin
                last_d = PORT0;
            end else if (state_d == OWN1) begin
                last_d = PORT1;
            end
        end else if ((acc0 || acc1) && cnt_q != MAXB) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            last_q    <= PORT1;
            cnt_q     <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            rvalid0_q <= acc0 & ~we0;
            rvalid1_q <= acc1 & ~we1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter with a
// behavioural memory and an ownership reference model.
module tb_mem_port_arbiter;

    localparam int MAX_BURST = 4;

    typedef struct {
        bit          we;
        logic [7:0]  addr;
        logic [15:0] data;
    } op_t;

    logic        clk_50MHz = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [7:0]  addr0 = '0, addr1 = '0;
    logic [15:0] wdata0 = '0, wdata1 = '0;
    logic        gnt0, gnt1, rvalid0, rvalid1, mem_wren;
    logic [15:0] rdata, mem_data, mem_q;
    logic [7:0]  mem_addr;
    logic [1:0]  owner;

    mem_port_arbiter #(.AW(8), .DW(16), .MAX_BURST(MAX_BURST)) dut (
        .clk_50MHz (clk_50MHz),
        .reset     (reset),
        .req0      (req0),
        .we0       (we0),
        .addr0     (addr0),
        .wdata0    (wdata0),
        .gnt0      (gnt0),
        .rvalid0   (rvalid0),
        .req1      (req1),
        .we1       (we1),
        .addr1     (addr1),
        .wdata1    (wdata1),
        .gnt1      (gnt1),
        .rvalid1   (rvalid1),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_wren  (mem_wren),
        .mem_q     (mem_q),
        .owner     (owner)
    );

    always #5 clk_50MHz = ~clk_50MHz;

    function automatic logic [15:0] init_val(input logic [7:0] a);
        return (a == 8'h10) ? 16'hABCD : {~a, a};
    endfunction

    // Synchronous memory with registered address
    logic        mem_init = 1'b1;
    logic [15:0] mem [256];
    logic [7:0]  maddr_q = '0;
    always @(posedge clk_50MHz) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(8'(i));
        end else if (mem_wren) begin
            mem[mem_addr] <= mem_data;
        end
        maddr_q <= mem_addr;
    end
    assign mem_q = mem[maddr_q];

    // Reference state: who owns the memory, plus expected read data
    logic [15:0] ref_mem [256];
    op_t         q0[$], q1[$];
    logic [15:0] sb0[$], sb1[$];
    int          m_own = -1;
    int          m_last = 1;
    int          m_run = 0;
    bit          m_rv0 = 0, m_rv1 = 0;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive();
        if (q0.size() > 0) begin
            req0 = 1'b1; we0 = q0[0].we; addr0 = q0[0].addr; wdata0 = q0[0].data;
        end else begin
            req0 = 1'b0; we0 = 1'($urandom); addr0 = 8'($urandom); wdata0 = 16'($urandom);
        end
        if (q1.size() > 0) begin
            req1 = 1'b1; we1 = q1[0].we; addr1 = q1[0].addr; wdata1 = q1[0].data;
        end else begin
            req1 = 1'b0; we1 = 1'($urandom); addr1 = 8'($urandom); wdata1 = 16'($urandom);
        end
    endtask

    task automatic push(input int p, input bit we, input logic [7:0] a, input logic [15:0] d);
        op_t o;
        o.we = we; o.addr = a; o.data = d;
        if (p == 0) q0.push_back(o);
        else q1.push_back(o);
        drive();
    endtask

    task automatic model_edge();
        int  nxt;
        bit  accd, mine, oth;
        accd = 0;
        m_rv0 = 0;
        m_rv1 = 0;
        if (m_own == 0 && req0) begin
            accd = 1;
            if (we0) ref_mem[addr0] = wdata0;
            else begin sb0.push_back(ref_mem[addr0]); m_rv0 = 1; end
            void'(q0.pop_front());
        end else if (m_own == 1 && req1) begin
            accd = 1;
            if (we1) ref_mem[addr1] = wdata1;
            else begin sb1.push_back(ref_mem[addr1]); m_rv1 = 1; end
            void'(q1.pop_front());
        end
        if (m_own < 0) begin
            if (req0 && req1) nxt = 1 - m_last;
            else if (req0) nxt = 0;
            else if (req1) nxt = 1;
            else nxt = -1;
        end else begin
            mine = (m_own == 0) ? req0 : req1;
            oth  = (m_own == 0) ? req1 : req0;
            if (!mine) nxt = oth ? 1 - m_own : -1;
            else if (oth && m_run + 1 >= MAX_BURST) nxt = 1 - m_own;
            else nxt = m_own;
        end
        if (nxt != m_own) begin
            m_run = 0;
            if (nxt >= 0) m_last = nxt;
        end else if (accd && m_run < MAX_BURST) begin
            m_run++;
        end
        m_own = nxt;
    endtask

    task automatic step();
        @(posedge clk_50MHz);
        if (!reset) model_edge();
        #2;
        drive();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Monitor: compares grants, mux and read returns at mid-cycle
    always @(negedge clk_50MHz) begin
        logic [1:0] eown;
        bit         ea0, ea1;
        logic [15:0] e;
        eown = (m_own < 0) ? 2'b00 : (m_own == 0) ? 2'b01 : 2'b10;
        ea0 = (m_own == 0) && req0;
        ea1 = (m_own == 1) && req1;
        chk("gnt0", 32'(gnt0), 32'(m_own == 0));
        chk("gnt1", 32'(gnt1), 32'(m_own == 1));
        chk("gnt_overlap", 32'(gnt0 & gnt1), 32'd0);
        chk("owner", 32'(owner), 32'(eown));
        chk("mem_wren", 32'(mem_wren), 32'((ea0 && we0) || (ea1 && we1)));
        chk("mem_addr", 32'(mem_addr), ea0 ? 32'(addr0) : ea1 ? 32'(addr1) : 32'd0);
        chk("mem_data", 32'(mem_data), ea0 ? 32'(wdata0) : ea1 ? 32'(wdata1) : 32'd0);
        chk("rvalid0", 32'(rvalid0), 32'(m_rv0));
        chk("rvalid1", 32'(rvalid1), 32'(m_rv1));
        if (rvalid0) begin
            if (sb0.size() == 0) chk("rdata0_unexpected", 32'd1, 32'd0);
            else begin e = sb0.pop_front(); chk("rdata0", 32'(rdata), 32'(e)); end
        end
        if (rvalid1) begin
            if (sb1.size() == 0) chk("rdata1_unexpected", 32'd1, 32'd0);
            else begin e = sb1.pop_front(); chk("rdata1", 32'(rdata), 32'(e)); end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
        drive();
        run(3);
        reset = 1'b0;
        mem_init = 1'b0;
        run(2);

        // single read on port 0
        push(0, 0, 8'h10, 16'h0);
        run(4);

        // write then readback on port 1
        push(1, 1, 8'h20, 16'h1234);
        push(1, 0, 8'h20, 16'h0);
        run(5);

        // sustained contention
        for (int i = 0; i < 12; i++) begin
            push(0, 1'($urandom), 8'($urandom_range(0, 15)), 16'($urandom));
            push(1, 1'($urandom), 8'($urandom_range(0, 15)), 16'($urandom));
        end
        run(30);

        // uncontested burst on port 1, port 0 joins mid-burst
        for (int i = 0; i < 10; i++) push(1, 1'($urandom), 8'($urandom), 16'($urandom));
        run(5);
        for (int i = 0; i < 6; i++) push(0, 0, 8'($urandom), 16'h0);
        run(25);

        // read on port 0 across a handover to port 1
        push(0, 1, 8'h05, 16'h5A5A);
        push(0, 1, 8'h06, 16'h0606);
        push(0, 1, 8'h07, 16'h0707);
        push(0, 0, 8'h05, 16'h0);
        push(1, 0, 8'h06, 16'h0);
        push(1, 0, 8'h07, 16'h0);
        run(15);

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 2) == 0 && q0.size() < 6)
                push(0, 1'($urandom), 8'($urandom_range(0, 31)), 16'($urandom));
            if ($urandom_range(0, 2) == 0 && q1.size() < 6)
                push(1, 1'($urandom), 8'($urandom_range(0, 31)), 16'($urandom));
            step();
        end
        run(30);

        // async reset in the middle of a port 0 read burst
        for (int i = 0; i < 8; i++) push(0, 0, 8'(i), 16'h0);
        run(3);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_gnt0", 32'(gnt0), 32'd0);
        chk("rst_rvalid0", 32'(rvalid0), 32'd0);
        chk("rst_mem_wren", 32'(mem_wren), 32'd0);
        q0.delete(); q1.delete(); sb0.delete(); sb1.delete();
        m_own = -1; m_last = 1; m_run = 0; m_rv0 = 0; m_rv1 = 0;
        drive();
        run(2);
        reset = 1'b0;
        push(0, 0, 8'h10, 16'h0);
        push(1, 0, 8'h20, 16'h0);
        step();
        #1;
        chk("first_gnt_after_rst", 32'({gnt1, gnt0}), 32'b01);
        run(10);

        chk("sb0_drained", 32'(sb0.size()), 32'd0);
        chk("sb1_drained", 32'(sb1.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
